// File: rtl/link_pkg.sv
// Shared definitions for the link alignment controller: FSM state encoding,
// the sync word pattern and the aligned word width.
package link_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] SYNC_WORD = 16'hF731;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    SEARCH = 3'd2,
    VERIFY = 3'd3,
    LOCKED = 3'd4
  } link_state_e;

endpackage

// File: rtl/link_align_ctrl_sync_mon.sv
// Sync word monitor: counts aligned words since the last sync (wc), good syncs
// seen while verifying (gc) and consecutive missed intervals while locked (mc).
module sync_mon
  import link_pkg::*;
#(
  parameter int unsigned SYNC_INTV = 256,
  parameter int unsigned LOCK_NUM  = 4,
  parameter int unsigned MISS_MAX  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              clear,
  input  logic              dopush,
  input  logic [WORD_W-1:0] dout,
  output logic              lock_ok,
  output logic              sync_lost
);

  localparam int WC_W = $clog2(SYNC_INTV) + 1;
  localparam int GC_W = $clog2(LOCK_NUM) + 1;
  localparam int MC_W = $clog2(MISS_MAX) + 1;

  localparam logic [WC_W-1:0] WC_LAST = WC_W'(SYNC_INTV - 1);
  localparam logic [WC_W-1:0] WC_FULL = WC_W'(SYNC_INTV);
  localparam logic [GC_W-1:0] GC_DONE = GC_W'(LOCK_NUM);
  localparam logic [MC_W-1:0] MC_FULL = MC_W'(MISS_MAX);

  logic [WC_W-1:0] wc;
  logic [GC_W-1:0] gc;
  logic [MC_W-1:0] mc;
  logic            is_sync;

  assign is_sync = dopush && (dout == SYNC_WORD);

  // A sync arriving on the wrap push takes the sync branch, so it never counts as a miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wc <= '0;
      gc <= '0;
      mc <= '0;
    end else if (clear) begin
      wc <= '0;
      gc <= '0;
      mc <= '0;
    end else if (is_sync) begin
      wc <= '0;
      mc <= '0;
      if (!mode && gc != GC_DONE) begin
        gc <= gc + 1'b1;
      end
    end else if (dopush) begin
      if (wc >= WC_LAST) begin
        if (mode) begin
          wc <= '0;
          if (mc != MC_FULL) begin
            mc <= mc + 1'b1;
          end
        end else begin
          wc <= WC_FULL;
        end
      end else begin
        wc <= wc + 1'b1;
      end
    end
  end

  assign lock_ok   = !mode && (gc == GC_DONE);
  assign sync_lost = mode ? (mc == MC_FULL) : (wc == WC_FULL);

endmodule

// File: rtl/link_align_ctrl.sv
// Link bring-up controller sequencing the receive word aligner through
// INIT/SEARCH/VERIFY/LOCKED. Optional relink statistics: LINK_ALIGN_STAT_EN.
module link_align_ctrl
  import link_pkg::*;
#(
  parameter int unsigned INIT_CYC  = 8,
  parameter int unsigned SRCH_TMO  = 4096,
  parameter int unsigned SYNC_INTV = 256,
  parameter int unsigned LOCK_NUM  = 4,
  parameter int unsigned MISS_MAX  = 3
) (
  input  logic              CLK,
  input  logic              RSTX,
  input  logic              ENABLE,
  input  logic              RELINK_REQ,
  input  logic              ALIGNED,
  input  logic              DOPUSH,
  input  logic [WORD_W-1:0] DOUT,
  output logic              PHY_INIT,
  output logic              LINK_UP,
  output logic              LINK_ERR,
  output logic [2:0]        STATE
`ifdef LINK_ALIGN_STAT_EN
  ,
  output logic [15:0]       RELINK_CNT
`endif
);

  localparam int unsigned T_MAX = (SRCH_TMO > INIT_CYC) ? SRCH_TMO : INIT_CYC;
  localparam int T_W = $clog2(T_MAX) + 1;
  localparam logic [T_W-1:0] INIT_LAST = T_W'(INIT_CYC - 1);
  localparam logic [T_W-1:0] TMO_LAST  = T_W'(SRCH_TMO - 1);

  link_state_e    state_q, state_d;
  logic [T_W-1:0] tmr;
  logic           fail;
  logic           restart;
  logic           entering;
  logic           mon_clear;
  logic           lock_ok;
  logic           sync_lost;

  assign entering  = restart || (state_d != state_q);
  assign mon_clear = entering || !(state_q inside {VERIFY, LOCKED});

  sync_mon #(
    .SYNC_INTV (SYNC_INTV),
    .LOCK_NUM  (LOCK_NUM),
    .MISS_MAX  (MISS_MAX)
  ) u_sync_mon (
    .clk       (CLK),
    .rst_n     (RSTX),
    .mode      (state_q == LOCKED),
    .clear     (mon_clear),
    .dopush    (DOPUSH),
    .dout      (DOUT),
    .lock_ok   (lock_ok),
    .sync_lost (sync_lost)
  );

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Disable beats a software relink, which beats every per-state rule.
  always_comb begin
    state_d = state_q;
    fail    = 1'b0;
    restart = 1'b0;
    if (!ENABLE) begin
      state_d = IDLE;
    end else if (RELINK_REQ) begin
      state_d = INIT;
      restart = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = INIT;
        INIT: begin
          if (tmr == INIT_LAST) begin
            state_d = SEARCH;
          end
        end
        SEARCH: begin
          if (ALIGNED) begin
            state_d = VERIFY;
          end else if (tmr == TMO_LAST) begin
            state_d = INIT;
            fail    = 1'b1;
          end
        end
        VERIFY: begin
          if (!ALIGNED || sync_lost) begin
            state_d = INIT;
            fail    = 1'b1;
          end else if (lock_ok) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (!ALIGNED || sync_lost) begin
            state_d = INIT;
            fail    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Shared INIT hold / SEARCH timeout timer, restarted on every state entry.
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      tmr <= '0;
    end else if (entering || !(state_q inside {INIT, SEARCH})) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      PHY_INIT <= 1'b1;
      LINK_UP  <= 1'b0;
      LINK_ERR <= 1'b0;
    end else begin
      PHY_INIT <= (state_d == IDLE) || (state_d == INIT);
      LINK_UP  <= (state_q == LOCKED);
      LINK_ERR <= fail;
    end
  end

  assign STATE = state_q;

`ifdef LINK_ALIGN_STAT_EN
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      RELINK_CNT <= '0;
    end else if (!ENABLE) begin
      RELINK_CNT <= '0;
    end else if (fail && RELINK_CNT != 16'hFFFF) begin
      RELINK_CNT <= RELINK_CNT + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_link_align_ctrl.sv
// Directed self-checking bench for link_align_ctrl (default parameters);
// RELINK_CNT checks are included when LINK_ALIGN_STAT_EN is defined.
module tb_link_align_ctrl;

  logic        CLK = 1'b0;
  logic        RSTX = 1'b1;
  logic        ENABLE = 1'b0;
  logic        RELINK_REQ = 1'b0;
  logic        ALIGNED = 1'b0;
  logic        DOPUSH = 1'b0;
  logic [15:0] DOUT = 16'h0000;
  logic        PHY_INIT;
  logic        LINK_UP;
  logic        LINK_ERR;
  logic [2:0]  STATE;
`ifdef LINK_ALIGN_STAT_EN
  logic [15:0] RELINK_CNT;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  link_align_ctrl dut (
    .CLK        (CLK),
    .RSTX       (RSTX),
    .ENABLE     (ENABLE),
    .RELINK_REQ (RELINK_REQ),
    .ALIGNED    (ALIGNED),
    .DOPUSH     (DOPUSH),
    .DOUT       (DOUT),
    .PHY_INIT   (PHY_INIT),
    .LINK_UP    (LINK_UP),
    .LINK_ERR   (LINK_ERR),
    .STATE      (STATE)
`ifdef LINK_ALIGN_STAT_EN
    ,
    .RELINK_CNT (RELINK_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic waitState(input string tag, input logic [2:0] target, input int budget);
    int n;
    n = 0;
    while (STATE !== target && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, {29'd0, STATE}, {29'd0, target});
  endtask

  // Pushes n plain words (optionally with two idle cycles after each, showing
  // the sync pattern without DOPUSH) and then optionally one sync word.
  task automatic applyStimulus(input int n_plain, input bit end_sync, input bit gaps);
    for (int i = 0; i < n_plain; i++) begin
      DOPUSH = 1'b1;
      DOUT   = 16'(i + 1);
      tick();
      if (gaps) begin
        DOPUSH = 1'b0;
        DOUT   = 16'hF731;
        tick();
        tick();
      end
    end
    if (end_sync) begin
      DOPUSH = 1'b1;
      DOUT   = 16'hF731;
      tick();
    end
    DOPUSH = 1'b0;
    DOUT   = 16'h0000;
  endtask

  initial begin
    int cnt;

    #2 RSTX = 1'b0;
    #20;
    checkOutput("rst_state", {29'd0, STATE}, 32'd0);
    checkOutput("rst_phy_init", {31'd0, PHY_INIT}, 32'd1);
    checkOutput("rst_link_up", {31'd0, LINK_UP}, 32'd0);
    checkOutput("rst_link_err", {31'd0, LINK_ERR}, 32'd0);
    RSTX = 1'b1;
    tick();

    // Bring-up: IDLE -> INIT for 8 cycles -> SEARCH
    ENABLE = 1'b1;
    tick();
    checkOutput("init_entry_state", {29'd0, STATE}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("init_hold_%0d", i), {31'd0, PHY_INIT}, 32'd1);
      tick();
    end
    checkOutput("search_state", {29'd0, STATE}, 32'd2);
    checkOutput("search_phy_init", {31'd0, PHY_INIT}, 32'd0);

    // SEARCH timeout with ALIGNED low
    cnt = 0;
    while (STATE === 3'd2 && cnt < 5000) begin
      cnt++;
      tick();
    end
    checkOutput("search_cycles", cnt, 32'd4096);
    checkOutput("tmo_state", {29'd0, STATE}, 32'd1);
    checkOutput("tmo_link_err", {31'd0, LINK_ERR}, 32'd1);
    checkOutput("tmo_phy_init", {31'd0, PHY_INIT}, 32'd1);
    tick();
    checkOutput("tmo_err_pulse", {31'd0, LINK_ERR}, 32'd0);
`ifdef LINK_ALIGN_STAT_EN
    checkOutput("cnt_after_tmo", {16'd0, RELINK_CNT}, 32'd1);
`endif

    // Verify with 100-word sync spacing, idle cycles between pushes
    ALIGNED = 1'b1;
    waitState("reach_verify_1", 3'd3, 30);
    applyStimulus(99, 1'b1, 1'b1);
    checkOutput("verify_gc1_state", {29'd0, STATE}, 32'd3);
    for (int g = 0; g < 3; g++) applyStimulus(99, 1'b1, 1'b1);
    checkOutput("verify_gc4_state", {29'd0, STATE}, 32'd3);
    checkOutput("verify_link_up", {31'd0, LINK_UP}, 32'd0);
    tick();
    checkOutput("locked_state", {29'd0, STATE}, 32'd4);
    checkOutput("locked_entry_link_up", {31'd0, LINK_UP}, 32'd0);
    tick();
    checkOutput("locked_link_up", {31'd0, LINK_UP}, 32'd1);

    // Two misses, a sync, two misses: still locked; one more miss relinks
    applyStimulus(512, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(512, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("two_miss_link_up", {31'd0, LINK_UP}, 32'd1);
    checkOutput("two_miss_state", {29'd0, STATE}, 32'd4);
    applyStimulus(256, 1'b0, 1'b0);
    checkOutput("third_miss_state", {29'd0, STATE}, 32'd4);
    checkOutput("third_miss_no_err", {31'd0, LINK_ERR}, 32'd0);
    tick();
    checkOutput("miss_relink_state", {29'd0, STATE}, 32'd1);
    checkOutput("miss_link_err", {31'd0, LINK_ERR}, 32'd1);
    checkOutput("miss_phy_init", {31'd0, PHY_INIT}, 32'd1);
    tick();
    checkOutput("miss_link_up_off", {31'd0, LINK_UP}, 32'd0);
    checkOutput("miss_err_pulse", {31'd0, LINK_ERR}, 32'd0);
`ifdef LINK_ALIGN_STAT_EN
    checkOutput("cnt_after_miss", {16'd0, RELINK_CNT}, 32'd2);
`endif

    // Sync landing on the wrap push keeps VERIFY alive
    waitState("reach_verify_2", 3'd3, 30);
    for (int g = 0; g < 3; g++) applyStimulus(255, 1'b1, 1'b0);
    checkOutput("wrap_sync_state", {29'd0, STATE}, 32'd3);
    applyStimulus(255, 1'b1, 1'b0);
    waitState("reach_locked_2", 3'd4, 5);
    tick();
    checkOutput("wrap_link_up", {31'd0, LINK_UP}, 32'd1);

    // Aligner drop while locked
    ALIGNED = 1'b0;
    tick();
    checkOutput("drop_state", {29'd0, STATE}, 32'd1);
    checkOutput("drop_link_err", {31'd0, LINK_ERR}, 32'd1);
    tick();
    checkOutput("drop_link_up_off", {31'd0, LINK_UP}, 32'd0);
    checkOutput("drop_err_pulse", {31'd0, LINK_ERR}, 32'd0);
`ifdef LINK_ALIGN_STAT_EN
    checkOutput("cnt_after_drop", {16'd0, RELINK_CNT}, 32'd3);
`endif

    // Software relink from LOCKED: no LINK_ERR, full INIT restart
    ALIGNED = 1'b1;
    waitState("reach_verify_3", 3'd3, 30);
    for (int g = 0; g < 4; g++) applyStimulus(10, 1'b1, 1'b0);
    waitState("reach_locked_3", 3'd4, 5);
    tick();
    checkOutput("relink_pre_link_up", {31'd0, LINK_UP}, 32'd1);
    RELINK_REQ = 1'b1;
    tick();
    RELINK_REQ = 1'b0;
    checkOutput("relink_state", {29'd0, STATE}, 32'd1);
    checkOutput("relink_no_err", {31'd0, LINK_ERR}, 32'd0);
    checkOutput("relink_phy_init", {31'd0, PHY_INIT}, 32'd1);
`ifdef LINK_ALIGN_STAT_EN
    checkOutput("cnt_after_relink", {16'd0, RELINK_CNT}, 32'd3);
`endif
    cnt = 0;
    while (STATE === 3'd1 && cnt < 50) begin
      cnt++;
      tick();
    end
    checkOutput("relink_init_cycles", cnt, 32'd8);

    // ENABLE low while in VERIFY
    tick();
    checkOutput("pre_disable_state", {29'd0, STATE}, 32'd3);
    ENABLE = 1'b0;
    tick();
    checkOutput("disable_state", {29'd0, STATE}, 32'd0);
    checkOutput("disable_phy_init", {31'd0, PHY_INIT}, 32'd1);
    checkOutput("disable_link_up", {31'd0, LINK_UP}, 32'd0);
`ifdef LINK_ALIGN_STAT_EN
    checkOutput("cnt_after_disable", {16'd0, RELINK_CNT}, 32'd0);
`endif

    // Asynchronous reset mid-SEARCH
    ENABLE  = 1'b1;
    ALIGNED = 1'b0;
    waitState("reach_search_4", 3'd2, 30);
    tick();
    tick();
    #3 RSTX = 1'b0;
    #1;
    checkOutput("async_rst_state", {29'd0, STATE}, 32'd0);
    checkOutput("async_rst_phy_init", {31'd0, PHY_INIT}, 32'd1);
    checkOutput("async_rst_link_up", {31'd0, LINK_UP}, 32'd0);
    checkOutput("async_rst_link_err", {31'd0, LINK_ERR}, 32'd0);
    #10 RSTX = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/link_align_ctrl.md
Name: link_align_ctrl

Overview:
Link-bring-up controller that sequences the 16-bit word aligner on the receive path.
- Drives the aligner's PHY_INIT and watches its ALIGNED flag and aligned word stream (DOPUSH/DOUT).
- Verifies lock by counting periodic sync words (16'hF731), then declares LINK_UP.
- Supervises the locked link and re-runs alignment on timeout, sync loss, aligner drop or software request.

Parameters:
- INIT_CYC, 8: cycles PHY_INIT is held high in INIT; min 1.
- SRCH_TMO, 4096: clock cycles allowed in SEARCH before giving up.
- SYNC_INTV, 256: max aligned words between consecutive sync words.
- LOCK_NUM, 4: sync words required in VERIFY before LINK_UP.
- MISS_MAX, 3: consecutive missed sync intervals in LOCKED before relink.

Ports:
- CLK  in  1  clock.
- RSTX  in  1  asynchronous active-low reset.
- ENABLE  in  1  level; 0 forces IDLE.
- RELINK_REQ  in  1  single-cycle pulse; restart alignment.
- ALIGNED  in  1  from aligner.
- DOPUSH  in  1  aligned word valid, from aligner.
- DOUT  in  16  aligned word, from aligner.
- PHY_INIT  out  1  to aligner; clears its sync state.
- LINK_UP  out  1  link locked.
- LINK_ERR  out  1  one-cycle pulse on any failure-triggered relink.
- STATE  out  3  current FSM state, for debug.

Behaviour:
- One clock domain, CLK. RSTX is asynchronous, active-low. All outputs are registered.
- Reset values: state=IDLE, PHY_INIT=1, LINK_UP=0, LINK_ERR=0, STATE=0, all counters 0.
- State encoding: IDLE=0, INIT=1, SEARCH=2, VERIFY=3, LOCKED=4.
- Transition priority, every cycle: ENABLE=0 -> IDLE; then RELINK_REQ -> INIT with no LINK_ERR; then the per-state rules below.
- IDLE: PHY_INIT=1. When ENABLE=1, go to INIT next cycle.
- INIT: PHY_INIT=1 for exactly INIT_CYC cycles, then go to SEARCH. The cycle counter clears on entry.
- SEARCH: PHY_INIT=0. Timer counts clocks from entry.
  - ALIGNED=1 -> VERIFY.
  - Else, at timer==SRCH_TMO-1 -> INIT and pulse LINK_ERR.
  - If ALIGNED is high on the timeout cycle, ALIGNED wins.
- VERIFY: word counter wc counts DOPUSH cycles; good-sync counter gc starts at 0 on entry.
  - DOPUSH with DOUT==16'hF731: gc++, wc<=0.
  - When gc reaches LOCK_NUM -> LOCKED.
  - wc reaching SYNC_INTV without a sync -> INIT and pulse LINK_ERR.
  - ALIGNED falling to 0 -> INIT and pulse LINK_ERR.
- LOCKED: LINK_UP=1, asserted the cycle after entry and deasserted the cycle after exit.
  - A sync word clears wc and the miss counter mc.
  - When wc reaches SYNC_INTV with no sync: mc++, wc<=0.
  - mc reaching MISS_MAX -> INIT and pulse LINK_ERR.
  - ALIGNED falling to 0 -> INIT and pulse LINK_ERR.
- Simultaneous sync word and wc wrap: the sync wins; no miss is counted.
- Non-DOPUSH cycles do not advance wc.
- Every entry to INIT restarts the whole sequence; all counters clear on state entry.
- Reset mid-operation returns all state and outputs to reset values asynchronously.
- Counter widths are $clog2 of the respective parameter plus 1; no counter wraps silently.

Optional Feature:
- Macro LINK_ALIGN_STAT_EN.
- Defined: adds output RELINK_CNT [15:0], a saturating count of LINK_ERR pulses (saturates at 16'hFFFF).
  - Clears on reset and while ENABLE=0.
  - RELINK_REQ-initiated relinks are not counted.
- Undefined: no port, no counter; behaviour otherwise identical.

Decomposition:
- Package link_pkg holds:
  - state enum/localparams IDLE..LOCKED;
  - SYNC_WORD=16'hF731;
  - the shared word width, 16.
- One natural sub-module, sync_mon: wc/gc/mc counters and sync compare.
  - Inputs: mode (verify/locked), clear, DOPUSH, DOUT.
  - Outputs: lock_ok, sync_lost.
- The FSM stays in link_align_ctrl.

Test Plan:
- Reset then ENABLE=1 -> PHY_INIT high for exactly 8 cycles after leaving IDLE, then low; STATE steps 0->1->2.
- SEARCH with ALIGNED held 0 -> LINK_ERR pulse at cycle 4096 of SEARCH, STATE=1, PHY_INIT=1 again.
- ALIGNED=1, then 4 sync words at 100-word spacing -> LINK_UP=1 after the 4th; then 3 intervals of 256 words with no F731 -> LINK_ERR pulse, LINK_UP=0, STATE=1.
- LOCKED, two missed intervals then one sync -> mc cleared; two further misses -> still LINK_UP=1.
- LOCKED, ALIGNED drops -> LINK_UP=0 and LINK_ERR pulse the next cycle; separately, RELINK_REQ in LOCKED -> INIT with no LINK_ERR, and with LINK_ALIGN_STAT_EN defined RELINK_CNT is unchanged.
- ENABLE=0 while in VERIFY, with RSTX asserted asynchronously mid-SEARCH -> IDLE with PHY_INIT=1 and LINK_UP=0; with LINK_ALIGN_STAT_EN defined, RELINK_CNT=0 after ENABLE=0.
